// File: rtl/wb_arb_if.sv
// Bundle of the writeback arbiter's request, lookup and register-file port signals.
// The slave modport is the arbiter's view; the master modport is the execute/memory side.
interface wb_arb_if #(
  parameter int XLEN = 32
);
  logic            alu_wr_en_i;
  logic [4:0]      alu_wr_addr_i;
  logic [XLEN-1:0] alu_wr_data_i;
  logic            dram_wr_en_i;
  logic [4:0]      dram_wr_addr_i;
  logic [XLEN-1:0] dram_wr_data_i;
  logic [4:0]      rs1_addr_i;
  logic [4:0]      rs2_addr_i;
  logic            rs1_hit_o;
  logic            rs2_hit_o;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            reg_wr_en_o;
  logic [4:0]      reg_wr_addr_o;
  logic [XLEN-1:0] reg_wr_data_o;
  logic            stall_o;
  logic            err_o;

  modport slave (
    input  alu_wr_en_i, alu_wr_addr_i, alu_wr_data_i,
    input  dram_wr_en_i, dram_wr_addr_i, dram_wr_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output rs1_hit_o, rs2_hit_o, rs1_data_o, rs2_data_o,
    output reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o,
    output stall_o, err_o
  );

  modport master (
    output alu_wr_en_i, alu_wr_addr_i, alu_wr_data_i,
    output dram_wr_en_i, dram_wr_addr_i, dram_wr_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  rs1_hit_o, rs2_hit_o, rs1_data_o, rs2_data_o,
    input  reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o,
    input  stall_o, err_o
  );
endinterface

// File: rtl/wb_arb.sv
// Writeback arbiter: load results own the register-file port, colliding ALU results
// wait in a small in-order FIFO that also serves forwarding lookups.
module wb_arb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  wb_arb_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            err_q;
  logic            ent_valid [DEPTH];
  logic [4:0]      ent_addr  [DEPTH];
  logic [XLEN-1:0] ent_data  [DEPTH];

  logic dram_vld;
  logic alu_vld;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic bypass;
  logic push;
  logic alu_viol;

  always_comb begin
    dram_vld   = bus.dram_wr_en_i && (bus.dram_wr_addr_i != 5'd0);
    alu_vld    = bus.alu_wr_en_i && (bus.alu_wr_addr_i != 5'd0);
    fifo_empty = (count == '0);
    fifo_full  = (count == CW'(DEPTH));
    pop        = !dram_vld && !fifo_empty;
    bypass     = !dram_vld && fifo_empty && alu_vld;
    push       = alu_vld && !bypass && !fifo_full;
    alu_viol   = alu_vld && fifo_full;
  end

  // Port outputs are held at zero while reset is asserted, whatever the inputs do.
  always_comb begin
    bus.reg_wr_en_o   = 1'b0;
    bus.reg_wr_addr_o = 5'd0;
    bus.reg_wr_data_o = '0;
    if (rst_n_i) begin
      if (dram_vld) begin
        bus.reg_wr_en_o   = 1'b1;
        bus.reg_wr_addr_o = bus.dram_wr_addr_i;
        bus.reg_wr_data_o = bus.dram_wr_data_i;
      end else if (!fifo_empty) begin
        bus.reg_wr_en_o   = ent_valid[rd_ptr];
        bus.reg_wr_addr_o = ent_addr[rd_ptr];
        bus.reg_wr_data_o = ent_data[rd_ptr];
      end else if (alu_vld) begin
        bus.reg_wr_en_o   = 1'b1;
        bus.reg_wr_addr_o = bus.alu_wr_addr_i;
        bus.reg_wr_data_o = bus.alu_wr_data_i;
      end
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    bus.rs1_hit_o  = 1'b0;
    bus.rs1_data_o = '0;
    bus.rs2_hit_o  = 1'b0;
    bus.rs2_data_o = '0;
    idx            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && ent_valid[idx]) begin
        if ((bus.rs1_addr_i != 5'd0) && (ent_addr[idx] == bus.rs1_addr_i)) begin
          bus.rs1_hit_o  = 1'b1;
          bus.rs1_data_o = ent_data[idx];
        end
        if ((bus.rs2_addr_i != 5'd0) && (ent_addr[idx] == bus.rs2_addr_i)) begin
          bus.rs2_hit_o  = 1'b1;
          bus.rs2_data_o = ent_data[idx];
        end
      end
    end
  end

  assign bus.stall_o = fifo_full;
  assign bus.err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_addr[i]  <= 5'd0;
        ent_data[i]  <= '0;
      end
    end else begin
      // A granted load overwrites every older deferred write to the same register.
      if (dram_vld) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_addr[i] == bus.dram_wr_addr_i) ent_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= bus.alu_wr_addr_i;
        ent_data[wr_ptr]  <= bus.alu_wr_data_i;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (alu_viol) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arb.sv
// Directed and random checks of wb_arb against a queue-based model of the
// grant, defer, kill and forwarding rules.
module tb_wb_arb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  wb_arb_if #(.XLEN(XLEN)) bus ();

  wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  bit   err_m = 1'b0;

  logic        obs_en, obs_h1, obs_h2, obs_stall, obs_err;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_d1, obs_d2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit aen, input logic [4:0] aa, input logic [31:0] ad,
                       input bit den, input logic [4:0] da, input logic [31:0] dd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_wr_en_i    = aen;
    bus.alu_wr_addr_i  = aa;
    bus.alu_wr_data_i  = ad;
    bus.dram_wr_en_i   = den;
    bus.dram_wr_addr_i = da;
    bus.dram_wr_data_i = dd;
    bus.rs1_addr_i     = r1;
    bus.rs2_addr_i     = r2;
  endtask

  task automatic lookup(input logic [4:0] rs, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'd0;
    if (rs != 5'd0) begin
      foreach (q[i]) begin
        if (q[i].v && q[i].a == rs) begin
          hit  = 1'b1;
          data = q[i].d;
        end
      end
    end
  endtask

  // One clock: drive, check against the model, advance the model, step past the edge.
  task automatic cycle(input bit aen, input logic [4:0] aa, input logic [31:0] ad,
                       input bit den, input logic [4:0] da, input logic [31:0] dd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit          dv, av, was_empty, was_full;
    logic        e_en, e_h1, e_h2;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_d1, e_d2;
    ent_t        e;
    drive(aen, aa, ad, den, da, dd, r1, r2);
    #1;
    dv        = den && (da != 5'd0);
    av        = aen && (aa != 5'd0);
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    e_en = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (dv) begin
      e_en = 1'b1; e_addr = da; e_data = dd;
    end else if (!was_empty) begin
      e_en = q[0].v; e_addr = q[0].a; e_data = q[0].d;
    end else if (av) begin
      e_en = 1'b1; e_addr = aa; e_data = ad;
    end
    lookup(r1, e_h1, e_d1);
    lookup(r2, e_h2, e_d2);
    obs_en    = bus.reg_wr_en_o;
    obs_addr  = bus.reg_wr_addr_o;
    obs_data  = bus.reg_wr_data_o;
    obs_h1    = bus.rs1_hit_o;
    obs_d1    = bus.rs1_data_o;
    obs_h2    = bus.rs2_hit_o;
    obs_d2    = bus.rs2_data_o;
    obs_stall = bus.stall_o;
    obs_err   = bus.err_o;
    check("wr_en", 64'(obs_en), 64'(e_en));
    check("wr_addr", 64'(obs_addr), 64'(e_addr));
    check("wr_data", 64'(obs_data), 64'(e_data));
    check("rs1_hit", 64'(obs_h1), 64'(e_h1));
    check("rs1_data", 64'(obs_d1), 64'(e_d1));
    check("rs2_hit", 64'(obs_h2), 64'(e_h2));
    check("rs2_data", 64'(obs_d2), 64'(e_d2));
    check("stall", 64'(obs_stall), 64'(was_full));
    check("err", 64'(obs_err), 64'(err_m));
    if (dv) begin
      foreach (q[i]) if (q[i].a == da) q[i].v = 1'b0;
    end
    if (!dv && !was_empty) void'(q.pop_front());
    if (av && (dv || !was_empty)) begin
      if (was_full) err_m = 1'b1;
      else begin
        e.v = 1'b1; e.a = aa; e.d = ad;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] r1);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 5'd5, 32'h11, 1, 5'd3, 32'h22, 5'd5, 5'd3);
    #12;
    check("rst_wr_en", 64'(bus.reg_wr_en_o), 64'd0);
    check("rst_wr_addr", 64'(bus.reg_wr_addr_o), 64'd0);
    check("rst_wr_data", 64'(bus.reg_wr_data_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_hit", 64'(bus.rs1_hit_o), 64'd0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // bypass
    cycle(1, 5'd5, 32'h11, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("byp_en", 64'(obs_en), 64'd1);
    check("byp_addr", 64'(obs_addr), 64'd5);
    check("byp_data", 64'(obs_data), 64'h11);
    idle(5'd5);
    check("byp_after_en", 64'(obs_en), 64'd0);
    check("byp_after_hit", 64'(obs_h1), 64'd0);
    check("byp_stall", 64'(obs_stall), 64'd0);

    // collision and drain
    cycle(1, 5'd4, 32'hBB, 1, 5'd3, 32'hAA, 5'd4, 5'd3);
    check("col_addr", 64'(obs_addr), 64'd3);
    check("col_data", 64'(obs_data), 64'hAA);
    check("col_hit_same", 64'(obs_h1), 64'd0);
    idle(5'd4);
    check("col_fwd_hit", 64'(obs_h1), 64'd1);
    check("col_fwd_data", 64'(obs_d1), 64'hBB);
    check("col_drain_addr", 64'(obs_addr), 64'd4);
    check("col_drain_data", 64'(obs_data), 64'hBB);
    idle(5'd4);
    check("col_empty_en", 64'(obs_en), 64'd0);
    check("col_empty_hit", 64'(obs_h1), 64'd0);

    // x0
    cycle(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 5'd0, 5'd0);
    check("x0_en", 64'(obs_en), 64'd0);
    check("x0_hit", 64'(obs_h1), 64'd0);
    idle(5'd0);
    check("x0_after_en", 64'(obs_en), 64'd0);

    // kill
    cycle(1, 5'd9, 32'h1, 1, 5'd1, 32'h5, 5'd0, 5'd0);
    cycle(1, 5'd9, 32'h3, 1, 5'd9, 32'h2, 5'd9, 5'd0);
    check("kill_dram_data", 64'(obs_data), 64'h2);
    check("kill_old_fwd", 64'(obs_d1), 64'h1);
    idle(5'd9);
    check("kill_pop_en", 64'(obs_en), 64'd0);
    check("kill_fwd_mid", 64'(obs_d1), 64'h3);
    idle(5'd9);
    check("kill_new_en", 64'(obs_en), 64'd1);
    check("kill_new_data", 64'(obs_data), 64'h3);
    check("kill_fwd_final", 64'(obs_d1), 64'h3);
    idle(5'd9);
    check("kill_done_en", 64'(obs_en), 64'd0);

    // full and stall
    cycle(1, 5'd6, 32'h66, 1, 5'd1, 32'h101, 5'd0, 5'd0);
    cycle(1, 5'd7, 32'h77, 1, 5'd2, 32'h102, 5'd6, 5'd7);
    check("full_stall_pre", 64'(obs_stall), 64'd0);
    cycle(1, 5'd8, 32'h88, 1, 5'd3, 32'h103, 5'd0, 5'd0);
    check("full_stall", 64'(obs_stall), 64'd1);
    idle(5'd8);
    check("full_err", 64'(obs_err), 64'd1);
    check("full_pop6", 64'(obs_addr), 64'd6);
    check("full_no8_fwd", 64'(obs_h1), 64'd0);
    idle(5'd0);
    check("full_pop7", 64'(obs_addr), 64'd7);
    check("full_stall_fall", 64'(obs_stall), 64'd0);
    idle(5'd0);
    check("full_empty_en", 64'(obs_en), 64'd0);

    // reset mid-operation
    cycle(1, 5'd10, 32'hA0, 1, 5'd1, 32'h1, 5'd0, 5'd0);
    cycle(1, 5'd11, 32'hB0, 1, 5'd2, 32'h2, 5'd0, 5'd0);
    drive(1, 5'd13, 32'hD0, 1, 5'd12, 32'hC0, 5'd10, 5'd11);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en", 64'(bus.reg_wr_en_o), 64'd0);
    check("mid_rst_addr", 64'(bus.reg_wr_addr_o), 64'd0);
    check("mid_rst_data", 64'(bus.reg_wr_data_o), 64'd0);
    check("mid_rst_stall", 64'(bus.stall_o), 64'd0);
    check("mid_rst_err", 64'(bus.err_o), 64'd0);
    check("mid_rst_hit1", 64'(bus.rs1_hit_o), 64'd0);
    check("mid_rst_hit2", 64'(bus.rs2_hit_o), 64'd0);
    q.delete();
    err_m = 1'b0;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      idle(5'd10);
      check("mid_rst_no_write", 64'(obs_en), 64'd0);
    end

    // random traffic obeying back-pressure
    for (int i = 0; i < 400; i++) begin
      bit aen;
      aen = ($urandom_range(0, 9) < 6) && (q.size() < DEPTH);
      cycle(aen, 5'($urandom_range(0, 7)), $urandom,
            bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
